// File: rtl/rf_wb_sequencer_pkg.sv
// rf_pkg: shared widths, PC address, sequencer state encoding and write-back holding buffer type
package rf_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] PC_REG = 4'd15;
  typedef enum logic [1:0] {IDLE, WR32, WR_LO, WR_HI} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] wa_lo;
    logic [ADDR_W-1:0] wa_hi;
    logic [DATA_W-1:0] wd_hi;
  } hold_t;
endpackage

// File: rtl/rf_wb_sequencer_if.sv
// rf_wb_sequencer_if: write-back request handshake (valid/ready, long flag, lo/hi address and data); master = controller, slave = sequencer
interface rf_wb_sequencer_if;
  import rf_pkg::*;
  logic wb_valid;
  logic wb_ready;
  logic wb_long;
  logic [ADDR_W-1:0] wb_wa_lo;
  logic [ADDR_W-1:0] wb_wa_hi;
  logic [DATA_W-1:0] wb_wd_lo;
  logic [DATA_W-1:0] wb_wd_hi;
  modport master(output wb_valid, wb_long, wb_wa_lo, wb_wa_hi, wb_wd_lo, wb_wd_hi, input wb_ready);
  modport slave(input wb_valid, wb_long, wb_wa_lo, wb_wa_hi, wb_wd_lo, wb_wd_hi, output wb_ready);
endinterface

// File: rtl/rf_wb_sequencer_hazard_cmp.sv
// rf_hazard_cmp: flags ra1/ra2 matching either valid pending address (a0/v0, a1/v1); reads of PC_REG never hazard
module rf_hazard_cmp
  import rf_pkg::*;
(
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] a0,
  input  logic [ADDR_W-1:0] a1,
  input  logic              v0,
  input  logic              v1,
  output logic              hazard
);
  function automatic logic hit(input logic [ADDR_W-1:0] ra);
    return ra != PC_REG && ((v0 && ra == a0) || (v1 && ra == a1));
  endfunction
  assign hazard = hit(ra1) || hit(ra2);
endmodule

// File: rtl/rf_wb_sequencer.sv
// rf_wb_sequencer: serialises short/long write-back requests onto the regfile write port; ports: clk, reset (sync active-low), wb (request slave), ra1/ra2 (hazard probes), rf_* (write port), pc_we/pc_wd (R15 redirect), hazard, busy
module rf_wb_sequencer
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  rf_wb_sequencer_if.slave  wb,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              rf_we3,
  output logic              rf_w_64,
  output logic [ADDR_W-1:0] rf_wa3_32,
  output logic [ADDR_W-1:0] rf_wa3_64,
  output logic [DATA_W-1:0] rf_wd3_32,
  output logic [DATA_W-1:0] rf_wd3_64,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wd,
  output logic              hazard,
  output logic              busy
);
  state_t state;
  hold_t  hold;
  logic   accept;
  assign wb.wb_ready = state != WR_LO;
  assign accept = wb.wb_valid && wb.wb_ready;
  assign busy = state != IDLE;
  rf_hazard_cmp u_hazard (
    .ra1(ra1), .ra2(ra2),
    .a0(hold.wa_lo), .v0(state == WR32 || state == WR_LO),
    .a1(hold.wa_hi), .v1(state == WR_LO || state == WR_HI),
    .hazard(hazard)
  );
  // The lo half is driven straight from the accepted request so its strobe is
  // visible in the cycle after acceptance; only the hi half comes from the buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      hold <= '0;
      rf_we3 <= 1'b0;
      rf_w_64 <= 1'b0;
      rf_wa3_32 <= '0;
      rf_wa3_64 <= '0;
      rf_wd3_32 <= '0;
      rf_wd3_64 <= '0;
      pc_we <= 1'b0;
      pc_wd <= '0;
    end else begin
      rf_we3 <= 1'b0;
      pc_we <= 1'b0;
      if (accept) begin
        hold <= '{wa_lo: wb.wb_wa_lo, wa_hi: wb.wb_wa_hi, wd_hi: wb.wb_wd_hi};
        state <= wb.wb_long ? WR_LO : WR32;
        rf_w_64 <= 1'b0;
        if (wb.wb_wa_lo == PC_REG) begin
          pc_we <= 1'b1;
          pc_wd <= wb.wb_wd_lo;
        end else begin
          rf_we3 <= 1'b1;
          rf_wa3_32 <= wb.wb_wa_lo;
          rf_wd3_32 <= wb.wb_wd_lo;
        end
      end else if (state == WR_LO) begin
        state <= WR_HI;
        rf_w_64 <= 1'b1;
        if (hold.wa_hi == PC_REG) begin
          pc_we <= 1'b1;
          pc_wd <= hold.wd_hi;
        end else begin
          rf_we3 <= 1'b1;
          rf_wa3_64 <= hold.wa_hi;
          rf_wd3_64 <= hold.wd_hi;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_sequencer.sv
// tb_rf_wb_sequencer: directed plus randomized stimulus checked against a queue-of-write-slots reference model
module tb_rf_wb_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] ra1 = '0, ra2 = '0;
  logic rf_we3, rf_w_64, pc_we, hazard, busy;
  logic [3:0] rf_wa3_32, rf_wa3_64;
  logic [31:0] rf_wd3_32, rf_wd3_64, pc_wd;
  int n_cmp = 0, n_bad = 0;
  rf_wb_sequencer_if wbi();
  rf_wb_sequencer dut (
    .clk(clk), .reset(reset), .wb(wbi.slave), .ra1(ra1), .ra2(ra2),
    .rf_we3(rf_we3), .rf_w_64(rf_w_64), .rf_wa3_32(rf_wa3_32), .rf_wa3_64(rf_wa3_64),
    .rf_wd3_32(rf_wd3_32), .rf_wd3_64(rf_wd3_64), .pc_we(pc_we), .pc_wd(pc_wd),
    .hazard(hazard), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {logic [3:0] a; logic [31:0] d; bit hi;} slot_t;
  slot_t q[$];
  slot_t cur;
  bit cur_v = 0, armed = 0;
  logic [3:0] l32a = '0, l64a = '0;
  logic [31:0] l32d = '0, l64d = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit exp_haz(input logic [3:0] ra);
    bit h = cur_v && cur.a == ra;
    foreach (q[i]) if (q[i].a == ra) h = 1;
    return ra != 4'd15 && h;
  endfunction
  task automatic step(input logic v, input logic lg, input logic [3:0] al, input logic [3:0] ah,
                      input logic [31:0] dl, input logic [31:0] dh,
                      input logic [3:0] r1, input logic [3:0] r2, input logic rn);
    bit rdy;
    #1;
    wbi.wb_valid = v; wbi.wb_long = lg; wbi.wb_wa_lo = al; wbi.wb_wa_hi = ah;
    wbi.wb_wd_lo = dl; wbi.wb_wd_hi = dh; ra1 = r1; ra2 = r2; reset = rn;
    rdy = q.size() == 0;
    @(negedge clk);
    if (armed) begin
      check("wb_ready", 32'(wbi.wb_ready), 32'(rdy));
      check("busy", 32'(busy), 32'(cur_v));
      check("hazard", 32'(hazard), 32'(exp_haz(r1) || exp_haz(r2)));
      check("rf_we3", 32'(rf_we3), 32'(cur_v && cur.a != 4'd15));
      check("pc_we", 32'(pc_we), 32'(cur_v && cur.a == 4'd15));
      if (cur_v && cur.a == 4'd15) check("pc_wd", pc_wd, cur.d);
      if (cur_v && cur.a != 4'd15) check("rf_w_64", 32'(rf_w_64), 32'(cur.hi));
      check("rf_wa3_32", 32'(rf_wa3_32), 32'(l32a));
      check("rf_wd3_32", rf_wd3_32, l32d);
      check("rf_wa3_64", 32'(rf_wa3_64), 32'(l64a));
      check("rf_wd3_64", rf_wd3_64, l64d);
    end
    @(posedge clk);
    if (!rn) begin
      q.delete();
      cur_v = 0;
      l32a = '0; l64a = '0; l32d = '0; l64d = '0;
      armed = 1;
    end else begin
      if (v && rdy) begin
        q.push_back('{a: al, d: dl, hi: 0});
        if (lg) q.push_back('{a: ah, d: dh, hi: 1});
      end
      cur_v = q.size() != 0;
      if (cur_v) begin
        cur = q.pop_front();
        if (cur.a != 4'd15) begin
          if (cur.hi) begin l64a = cur.a; l64d = cur.d; end
          else begin l32a = cur.a; l32d = cur.d; end
        end
      end
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 3, 0, 32'hDEADBEEF, 0, 0, 0, 1);
    idle(2);
    step(1, 1, 4, 5, 32'h11111111, 32'h22222222, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 4; i++) step(1, 0, 4'(i), 0, 32'h1000 + 32'(i), 0, 0, 0, 1);
    idle(2);
    step(1, 1, 15, 2, 32'h00000100, 32'hABCD0000, 0, 0, 1);
    idle(3);
    step(1, 1, 6, 7, 32'h6, 32'h7, 7, 15, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 7, 15, 1);
    step(1, 1, 8, 9, 32'h8, 32'h9, 9, 8, 1);
    step(0, 0, 0, 0, 0, 0, 9, 8, 0);
    idle(2);
    step(1, 1, 10, 10, 32'hAAAA, 32'hBBBB, 10, 0, 1);
    idle(3);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, 1'($urandom), 4'($urandom), 4'($urandom),
           $urandom, $urandom, 4'($urandom), 4'($urandom), $urandom_range(0, 49) != 0);
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
